apu_frame_counter: RTL
======================

Name: apu_frame_counter

Overview:
APU frame sequencer. Counts CPU cycles and generates the quarter-frame and half-frame clock enables. The quarter-frame enable drives the linear counter and envelopes; the half-frame enable drives the length counters and sweeps. Also owns the frame IRQ flag and the $4017 mode/inhibit register, including its delayed sequencer-reset behaviour.

Parameters:
CNT_WIDTH, 16, width of the CPU-cycle step counter
STEP1, 7457, CPU cycle of the 1st quarter event
STEP2, 14913, CPU cycle of the 2nd quarter event plus the 1st half event
STEP3, 22371, CPU cycle of the 3rd quarter event
STEP4, 29829, 4-step mode: quarter + half + IRQ event
STEP5, 37281, 5-step mode: quarter + half event

Ports:
clk  input  1  system clock
rst_l  input  1  asynchronous reset, active low
cpu_clk_en  input  1  one-clk-wide CPU cycle strobe; all state advances only on it
reg_we  input  1  $4017 write, qualified by cpu_clk_en
mode_in  input  1  write data bit 7: 0 = 4-step, 1 = 5-step
irq_inhibit_in  input  1  write data bit 6
status_read  input  1  $4015 read, qualified by cpu_clk_en; clears the IRQ flag
quarter_clk_en  output  1  one-clk pulse, coincident with cpu_clk_en
half_clk_en  output  1  one-clk pulse, coincident with cpu_clk_en
frame_irq  output  1  frame IRQ flag level

Behaviour:
- Clock and reset: single clock clk; rst_l is asynchronous and active low. Reset state: count=0, mode=0, inhibit=0, irq flag=0, parity=0, no reset pending. Outputs after reset: quarter_clk_en=0, half_clk_en=0, frame_irq=0.
- Enable gating: all registers update only when cpu_clk_en=1.
- Output decode: quarter_clk_en and half_clk_en are decoded combinationally from the registered state ANDed with cpu_clk_en. Each pulse is therefore exactly one clk wide and never asserted without cpu_clk_en.
- Parity: 1-bit, toggles on every cpu_clk_en.
- Counter, normal step: count increments by 1 per cpu_clk_en. Events are decoded on the current count value.
- Mode 0 (4-step):
  - quarter at STEP1, STEP2, STEP3, STEP4.
  - half at STEP2, STEP4.
  - irq-set at STEP4-1, STEP4, STEP4+1.
  - At count==STEP4+1, next count=0.
- Mode 1 (5-step):
  - quarter at STEP1, STEP2, STEP3, STEP5.
  - half at STEP2, STEP5.
  - No IRQ; no event at STEP4.
  - At count==STEP5+1, next count=0.
- $4017 write (cpu_clk_en & reg_we):
  - mode and inhibit load immediately.
  - If irq_inhibit_in=1, the irq flag clears in the same update.
  - A reset-delay counter loads 3 if parity=0, or 4 if parity=1.
- Reset delay: decrements on each subsequent cpu_clk_en. On the cpu_clk_en where it is 1:
  - count loads 0 instead of incrementing, and no table event fires.
  - If mode=1, quarter and half pulse on that enable.
  - The pending state clears.
- Repeated write: a second write while a reset is pending reloads the delay from the current parity.
- IRQ flag set: on irq-set when mode=0 and inhibit=0. frame_irq is registered and appears the cycle after.
- IRQ flag clear: cleared by status_read. If set and clear coincide on the same enable, set wins.
- Mid-operation reset: asserting rst_l low mid-sequence returns immediately to the reset state. Any pending delay is lost.
- Counter width: never overflows; maximum value STEP5+1 < 2^CNT_WIDTH.

Test Plan:
- 4-step sequence: reset, free-run cpu_clk_en every 2nd clk in mode 0 -> quarter at counts 7457/14913/22371/29829; half at 14913/29829; frame_irq rises after 29828; count wraps to 0 after 29830 and the pattern repeats.
- 5-step sequence: write mode_in=1, inhibit=0, then run -> quarter at 7457/14913/22371/37281; half at 14913/37281; frame_irq stays 0 throughout.
- Write delay and parity: write mode_in=1 at parity 0 -> quarter+half pulse exactly 3 enables later and count restarts at 0. Repeat with the write at parity 1 -> 4 enables later. Mode 0 write -> no pulses, count restart only.
- IRQ control: let frame_irq set; write irq_inhibit_in=1 -> frame_irq=0 next cycle and stays 0 across STEP4. Separately, with the flag set, status_read -> cleared. status_read at count STEP4 -> flag remains 1 (set wins).
- Mid-sequence reset: assert rst_l low at count ~20000 with a reset pending -> all outputs 0 asynchronously. After release, first quarter pulse at count 7457 with mode=0.
- Enable gating: hold cpu_clk_en=0 for 1000 clks with reg_we/status_read toggling -> no state change and no output pulses.

Source files
------------

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: counts CPU cycles, emits the quarter-frame and
// half-frame clock enables, owns the frame IRQ flag and the $4017
// mode/inhibit register with its parity-dependent delayed sequencer reset.
module apu_frame_counter #(
    parameter int CNT_WIDTH = 16,
    parameter int STEP1     = 7457,
    parameter int STEP2     = 14913,
    parameter int STEP3     = 22371,
    parameter int STEP4     = 29829,
    parameter int STEP5     = 37281
) (
    input  logic clk,
    input  logic rst_l,
    input  logic cpu_clk_en,
    input  logic reg_we,
    input  logic mode_in,
    input  logic irq_inhibit_in,
    input  logic status_read,
    output logic quarter_clk_en,
    output logic half_clk_en,
    output logic frame_irq
);

    // Step-table compare points, sized to the counter.
    localparam logic [CNT_WIDTH-1:0] S1   = CNT_WIDTH'(STEP1);
    localparam logic [CNT_WIDTH-1:0] S2   = CNT_WIDTH'(STEP2);
    localparam logic [CNT_WIDTH-1:0] S3   = CNT_WIDTH'(STEP3);
    localparam logic [CNT_WIDTH-1:0] S4M1 = CNT_WIDTH'(STEP4 - 1);
    localparam logic [CNT_WIDTH-1:0] S4   = CNT_WIDTH'(STEP4);
    localparam logic [CNT_WIDTH-1:0] S4P1 = CNT_WIDTH'(STEP4 + 1);
    localparam logic [CNT_WIDTH-1:0] S5   = CNT_WIDTH'(STEP5);
    localparam logic [CNT_WIDTH-1:0] S5P1 = CNT_WIDTH'(STEP5 + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Registered state.
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 mode_q, mode_d;
    logic                 inhibit_q, inhibit_d;
    logic                 irq_q, irq_d;
    logic                 parity_q, parity_d;
    // Delayed-reset countdown; 0 means no sequencer reset pending.
    logic [2:0]           delay_q, delay_d;

    // Decoded events for the current count.
    logic delay_fire;
    logic seq_end;
    logic tbl_quarter;
    logic tbl_half;
    logic tbl_irq;
    logic quarter_ev;
    logic half_ev;
    logic irq_set;

    // Decode table events from the current count; a firing delayed reset
    // overrides the table and pulses both enables only in 5-step mode.
    always_comb begin
        delay_fire  = (delay_q == 3'd1);
        tbl_quarter = (count_q == S1) || (count_q == S2) || (count_q == S3) ||
                      (mode_q ? (count_q == S5) : (count_q == S4));
        tbl_half    = (count_q == S2) ||
                      (mode_q ? (count_q == S5) : (count_q == S4));
        tbl_irq     = !mode_q &&
                      ((count_q == S4M1) || (count_q == S4) || (count_q == S4P1));
        seq_end     = mode_q ? (count_q == S5P1) : (count_q == S4P1);
        quarter_ev  = delay_fire ? mode_q : tbl_quarter;
        half_ev     = delay_fire ? mode_q : tbl_half;
        irq_set     = !delay_fire && tbl_irq && !inhibit_q;
    end

    // Compute next state; nothing moves unless the CPU-cycle strobe is high.
    always_comb begin
        count_d   = count_q;
        mode_d    = mode_q;
        inhibit_d = inhibit_q;
        irq_d     = irq_q;
        parity_d  = parity_q;
        delay_d   = delay_q;
        if (cpu_clk_en) begin
            parity_d = ~parity_q;

            if (delay_fire || seq_end) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_ONE;
            end

            // A write (re)arms the countdown from the parity seen by the write;
            // otherwise a pending countdown keeps running down to idle.
            if (reg_we) begin
                delay_d = parity_q ? 3'd4 : 3'd3;
            end else if (delay_q != 3'd0) begin
                delay_d = delay_q - 3'd1;
            end

            if (reg_we) begin
                mode_d    = mode_in;
                inhibit_d = irq_inhibit_in;
            end

            // Status read clears, a table set overrides the read, and setting
            // the inhibit bit forces the flag low regardless.
            if (status_read) begin
                irq_d = 1'b0;
            end
            if (irq_set) begin
                irq_d = 1'b1;
            end
            if (reg_we && irq_inhibit_in) begin
                irq_d = 1'b0;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q   <= '0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
            parity_q  <= 1'b0;
            delay_q   <= 3'd0;
        end else begin
            count_q   <= count_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
            parity_q  <= parity_d;
            delay_q   <= delay_d;
        end
    end

    // Pulses are qualified by the strobe so each one is exactly one clk wide.
    always_comb begin
        quarter_clk_en = cpu_clk_en && quarter_ev;
        half_clk_en    = cpu_clk_en && half_ev;
        frame_irq      = irq_q;
    end

endmodule
